// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: CPU store bus as seen by the
// memory-mapped UART transmitter.
interface io_uart_tx_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write;

  modport master (
    output address,
    output data_in,
    output write
  );

  modport slave (
    input address,
    input data_in,
    input write
  );
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 serial transmitter with
// a one-entry holding register and a pollable status byte.
module io_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  TX_DATA_ADDR = 8'hE0,
  parameter logic [7:0]  TX_CTRL_ADDR = 8'hE1
) (
  input  logic        clock,
  input  logic        reset,
  io_uart_tx_if.slave bus,
  output logic        txd,
  output logic [7:0]  status_out,
  output logic        tx_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0] BAUD_LAST =
    8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] BAUD_PRE =
    8'(CLKS_PER_BIT - 2);

  logic [1:0] state;
  logic [7:0] shift_reg;
  logic [7:0] hold_data;
  logic [2:0] bit_idx;
  logic [7:0] baud_cnt;
  logic       hold_full;
  logic       overrun;

  logic wr_data;
  logic wr_ctrl;
  logic baud_last;
  logic load;
  logic free;

  assign wr_data = bus.write &&
    (bus.address == TX_DATA_ADDR);
  assign wr_ctrl = bus.write &&
    (bus.address == TX_CTRL_ADDR);

  assign baud_last = (baud_cnt == BAUD_LAST);

  // The held byte moves to the shifter from IDLE or at
  // the end of a stop bit, so a store on that edge fits.
  assign load = hold_full &&
    ((state == IDLE) ||
     ((state == STOP) && baud_last));
  assign free = !hold_full || load;

  assign status_out = {
    5'b0,
    overrun,
    state != IDLE,
    ~hold_full
  };

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_data && free) begin
        hold_data <= bus.data_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (wr_data && !free) begin
        overrun <= 1'b1;
      end else if (wr_ctrl && bus.data_in[2]) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= 8'h00;
      bit_idx   <= 3'd0;
      baud_cnt  <= 8'd0;
      txd       <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= (state == STOP) &&
        (baud_cnt == BAUD_PRE);
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            shift_reg <= hold_data;
            baud_cnt  <= 8'd0;
            state     <= START;
            txd       <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= 8'd0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            txd      <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt  <= 8'd0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= 8'd0;
            if (hold_full) begin
              shift_reg <= hold_data;
              state     <= START;
              txd       <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: scoreboard bench; a timeline model of
// accepted bytes predicts frames, a monitor decodes txd.
module tb_io_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  typedef struct {
    logic [7:0] d;
    int         e;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd;
  logic       tx_done;
  logic [7:0] status_out;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clock     (clk),
    .reset     (rst_n),
    .bus       (bus),
    .txd       (txd),
    .status_out(status_out),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   acc_e[$];
  int   xf_e[$];
  bit   ov = 0;
  bit   mon_busy = 0;

  task automatic chk(input string name,
                     input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h",
               name, cyc, got, want);
    end
  endtask

  // Byte accepted before edge e and not yet shifted out.
  function automatic bit hold_occ(input int e);
    foreach (acc_e[i])
      if (acc_e[i] < e && xf_e[i] > e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int last_end();
    if (xf_e.size() == 0) return -1;
    return xf_e[xf_e.size() - 1] + FRAME;
  endfunction

  function automatic logic [7:0] exp_status(input int k);
    bit rdy;
    bit bsy;
    rdy = 1'b1;
    bsy = 1'b0;
    foreach (acc_e[i]) begin
      if (acc_e[i] <= k && k < xf_e[i]) rdy = 1'b0;
      if (xf_e[i] <= k && k < xf_e[i] + FRAME) bsy = 1'b1;
    end
    return {5'b0, ov, bsy, rdy};
  endfunction

  task automatic check_status(input string name);
    chk(name, int'(status_out), int'(exp_status(cyc)));
  endtask

  // Called at a negedge; the store lands on the next edge.
  task automatic store(input logic [7:0] a,
                       input logic [7:0] d,
                       input bit we);
    int e;
    int x;
    e = cyc + 1;
    bus.address = a;
    bus.data_in = d;
    bus.write   = we;
    if (we && a == 8'hE0) begin
      if (hold_occ(e)) begin
        ov = 1'b1;
      end else begin
        x = (last_end() > e + 1) ? last_end() : e + 1;
        acc_e.push_back(e);
        xf_e.push_back(x);
        q.push_back('{d, x});
      end
    end else if (we && a == 8'hE1 && d[2]) begin
      ov = 1'b0;
    end
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((q.size() != 0 || mon_busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain"}, q.size() + int'(mon_busy), 0);
    idle(2);
  endtask

  task automatic clear_model();
    q.delete();
    acc_e.delete();
    xf_e.delete();
    ov = 1'b0;
  endtask

  logic smp_txd  [FRAME];
  logic smp_done [FRAME];

  initial begin : monitor
    int   start;
    bit   aborted;
    exp_t x;
    logic [7:0] got;
    int   bad_shape;
    int   bad_done;
    int   bn;
    logic lvl;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (txd !== 1'b0) begin
        if (tx_done !== 1'b0)
          chk("idle_tx_done", int'(tx_done), 0);
        continue;
      end
      mon_busy = 1'b1;
      start = cyc;
      aborted = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        smp_txd[i]  = txd;
        smp_done[i] = tx_done;
      end
      mon_busy = 1'b0;
      if (aborted) continue;
      if (q.size() == 0) begin
        chk("unexpected_frame", start, -1);
        continue;
      end
      x = q.pop_front();
      chk("frame_start_cycle", start, x.e);
      for (int b = 0; b < 8; b++)
        got[b] = smp_txd[(b + 1) * C + C / 2];
      chk("frame_byte", int'(got), int'(x.d));
      bad_shape = 0;
      bad_done = 0;
      for (int i = 0; i < FRAME; i++) begin
        bn = i / C;
        if (bn == 0) lvl = 1'b0;
        else if (bn == 9) lvl = 1'b1;
        else lvl = x.d[bn - 1];
        if (smp_txd[i] !== lvl) bad_shape++;
        if (smp_done[i] !== (i == FRAME - 1)) bad_done++;
      end
      chk("frame_waveform", bad_shape, 0);
      chk("frame_tx_done", bad_done, 0);
    end
  end

  initial begin : stim
    int bad;
    int x0;
    int r;
    logic [7:0] a;
    bus.address = 8'h00;
    bus.data_in = 8'h00;
    bus.write   = 1'b0;
    idle(3);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({txd, tx_done, status_out} !== {2'b10, 8'h01})
        bad++;
    end
    chk("reset_idle_50", bad, 0);

    store(8'hE0, 8'hA5, 1'b1);
    check_status("a5_after_store");
    chk("a5_txd_before_start", int'(txd), 1);
    @(negedge clk);
    check_status("a5_frame_running");
    chk("a5_start_low", int'(txd), 0);
    drain("a5");
    chk("a5_status_idle", int'(status_out), 8'h01);

    store(8'hE0, 8'h55, 1'b1);
    store(8'hE0, 8'h0F, 1'b1);
    check_status("b2b_both_held");
    drain("b2b");
    check_status("b2b_no_overrun");

    store(8'hE0, 8'h3C, 1'b1);
    store(8'hE0, 8'hC3, 1'b1);
    store(8'hE0, 8'h99, 1'b1);
    idle(2);
    check_status("ovr_set");
    drain("ovr");
    check_status("ovr_sticky");
    store(8'hE1, 8'h04, 1'b1);
    check_status("ovr_cleared");

    store(8'hE2, 8'hFF, 1'b1);
    store(8'hE0, 8'hFF, 1'b0);
    store(8'hF0, 8'hFF, 1'b1);
    idle(3 * FRAME);
    chk("ignored_status", int'(status_out), 8'h01);
    chk("ignored_no_frames", q.size(), 0);

    store(8'hE0, 8'hF0, 1'b1);
    store(8'hE0, 8'h3C, 1'b1);
    x0 = xf_e[0];
    while (cyc < x0 + 4 * C + 1) @(negedge clk);
    check_status("rst_hold_full");
    chk("rst_bit3_low", int'(txd), 0);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_async_txd", int'(txd), 1);
    idle(3);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || status_out !== 8'h01) bad++;
    end
    chk("rst_no_residual", bad, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) a = 8'hE0;
      else if (r < 8) a = 8'hE1;
      else a = 8'($urandom_range(0, 255));
      store(a, 8'($urandom_range(0, 255)),
            $urandom_range(0, 7) != 0);
      check_status("rand_status");
      idle($urandom_range(0, 2 * FRAME));
    end
    drain("rand");
    check_status("final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped serial transmitter on the CPU's I/O port space. It watches the CPU store bus (address, data, write) and accepts bytes written to the TX data port. Each byte is buffered in a one-entry holding register and shifted out as 8N1 asynchronous serial, LSB first. A status byte is presented for wiring onto the memory block's input port at F0, so the CPU can poll readiness with a load.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..255.
- TX_DATA_ADDR, 8'hE0: store address that enqueues a byte.
- TX_CTRL_ADDR, 8'hE1: store address for the control write; data bit 2 = 1 clears overrun.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  8  CPU memory address (MAR), shared with memory.
- data_in  in  8  CPU store data (to_memory), shared with memory.
- write  in  1  CPU store strobe; sampled at the rising edge.
- txd  out  1  serial output; idles high.
- status_out  out  8  status byte, {5'b0, overrun, busy, ready}.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Store detection:
  - wr_data = write && address == TX_DATA_ADDR.
  - wr_ctrl = write && address == TX_CTRL_ADDR.
  - All other addresses are ignored.
- Holding register: 8-bit hold_data plus hold_full flag.
  - The holding register is "free" this cycle if hold_full=0, or if its contents transfer to the shifter at this same edge.
  - wr_data while free: hold_data<=data_in, hold_full<=1.
  - wr_data while not free: byte dropped, overrun<=1, hold_data unchanged.
- Shifter FSM states: IDLE, START, DATA, STOP.
  - Registers: 8-bit shift_reg, 3-bit bit_idx, baud counter baud_cnt counting 0..CLKS_PER_BIT-1.
  - IDLE: txd=1. If hold_full, move hold_data to shift_reg, clear hold_full, baud_cnt<=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then bit_idx<=0 and go to DATA.
  - DATA: txd=shift_reg[0] for CLKS_PER_BIT cycles. Then shift right; if bit_idx==7 go to STOP, else bit_idx+1.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the last cycle, tx_done=1.
    - If hold_full: transfer hold_data to shift_reg and go to START (back-to-back, no idle bit).
    - Otherwise go to IDLE.
- Status bits:
  - ready = ~hold_full.
  - busy = (state != IDLE).
  - overrun is sticky; it is cleared by wr_ctrl with data_in[2]=1.
  - A set and a clear in the same cycle leave overrun=1 (set wins).
- txd, tx_done and status_out are registered outputs; there are no combinational paths from the inputs.

## Timing
- Reset values: txd=1, status_out=8'h01, tx_done=0, state IDLE, hold_full=0, overrun=0.
- Reset asserted mid-frame: txd goes to 1 asynchronously, the frame and the held byte are discarded, and the block returns to IDLE.
- Store at edge N with shifter idle:
  - Edge N: hold_full=1, so ready=0 after N.
  - Edge N+1: transfer; state=START, txd=0, ready=1, busy=1.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first txd=0 to the end of the stop bit.
  - tx_done is high during the final stop cycle.
  - busy drops the cycle after, unless a back-to-back frame starts.
- Back-to-back frames: the next start bit begins on the cycle right after the last stop cycle, with zero idle cycles.
- Capacity: 2 bytes (shifter + holding register).
  - A third store before the first frame finishes its stop bit sets overrun.
  - A store landing on the transfer edge is accepted with no overrun.
- baud_cnt resets to 0 at every state entry; bit boundaries have no drift.

## Test plan
- Reset, then idle 50 cycles.
  - Required: txd=1, status_out=8'h01, tx_done=0 throughout.
- CLKS_PER_BIT=4; store 8'hA5 to E0 at edge N.
  - Required: ready=0 after N; txd=0 from N+1 for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1, each 4 cycles; then stop high 4 cycles.
  - tx_done pulses once, 40 cycles after N+1; status returns to 8'h01.
- Store 8'h55 then 8'h0F on consecutive stores.
  - Required: two frames with no idle gap between stop and start; overrun stays 0.
  - Decoded bytes are 8'h55 then 8'h0F.
- Store three bytes within 5 cycles.
  - Required: the third byte is dropped, status bit2=1, and only two frames are sent.
  - Then store 8'h04 to E1: status bit2=0.
- Store 8'hFF to E2, E0 with write=0, and F0.
  - Required: no frame starts; status stays 8'h01.
- Assert reset during bit 3 of a frame with the holding register full.
  - Required: txd=1 immediately; after release, status=8'h01 and no residual frame is sent.
